bpsk_frame_controller: RTL and testbench

- Downstream consumer of the push-button debouncer's single-cycle `PB_db` pulse.
- Each accepted press latches an 8-bit payload and serialises one fixed frame at symbol rate to the BPSK modulator: 8-bit preamble, then 8-bit sync word, then 8-bit payload, all MSB first.
- After the frame it holds a silent guard gap, then returns to idle.
- Optional differential encoding of the bit stream for the modulator.

---
 rtl/bpsk_frame_controller.sv | 157 +++++++++++++++
 tb/tb_bpsk_frame_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_controller.sv
// rtl/bpsk_frame_controller.sv - press-triggered BPSK frame serialiser
// Sends {PREAMBLE, SYNC_WORD, payload} MSB first at symbol rate, then a silent guard gap.
module bpsk_frame_controller #(
  parameter int unsigned SYM_DIV   = 250,
  parameter logic [7:0]  PREAMBLE  = 8'hAA,
  parameter logic [7:0]  SYNC_WORD = 8'h7E,
  parameter int unsigned GAP_SYMS  = 4,
  parameter bit          DIFF_EN   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx_bit,
  output logic       tx_en,
  output logic       sym_strobe,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] SYM_LAST = 16'(SYM_DIV - 1);
  localparam logic [7:0]  GAP_LAST = (GAP_SYMS == 0) ? 8'd0 : 8'(GAP_SYMS - 1);
  localparam bit          HAS_GAP  = (GAP_SYMS != 0);
  localparam logic [4:0]  BIT_LAST = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start_d;
  // Frame bits 22..0; bit 23 is PREAMBLE[7] and is emitted straight from the accept edge.
  logic [22:0] shreg;
  logic [15:0] sym_cnt;
  logic [4:0]  bit_idx;
  logic [7:0]  gap_cnt;

  logic start_rise;
  logic accept;
  logic sym_last;
  logic bit_last;
  logic gap_last;
  logic next_bit;

  assign start_rise = start & ~start_d;
  // done marks the cycle busy fell; a rise landing there is dropped.
  assign accept     = (state == IDLE) && start_rise && !done;
  assign sym_last   = (sym_cnt == SYM_LAST);
  assign bit_last   = (bit_idx == BIT_LAST);
  assign gap_last   = (gap_cnt == GAP_LAST);
  // While sending, tx_bit already holds the previous encoded bit e[k-1].
  assign next_bit   = DIFF_EN ? (tx_bit ^ shreg[22]) : shreg[22];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FRAME;
        end
      end
      FRAME: begin
        if (sym_last && bit_last) begin
          state_nxt = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (sym_last && gap_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d    <= 1'b0;
      shreg      <= '0;
      sym_cnt    <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      tx_bit     <= 1'b0;
      tx_en      <= 1'b0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      start_d    <= start;
      sym_strobe <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= {PREAMBLE[6:0], SYNC_WORD, data_in};
            sym_cnt    <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            // e[0] = 0 ^ f[0], so raw and encoded first bits agree.
            tx_bit     <= PREAMBLE[7];
            tx_en      <= 1'b1;
            sym_strobe <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FRAME: begin
          if (sym_last) begin
            sym_cnt <= '0;
            if (bit_last) begin
              tx_en   <= 1'b0;
              tx_bit  <= 1'b0;
              gap_cnt <= '0;
              if (!HAS_GAP) begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              bit_idx    <= bit_idx + 5'd1;
              shreg      <= {shreg[21:0], 1'b0};
              tx_bit     <= next_bit;
              sym_strobe <= 1'b1;
            end
          end else begin
            sym_cnt <= sym_cnt + 16'd1;
          end
        end
        GAP: begin
          if (sym_last) begin
            sym_cnt <= '0;
            if (gap_last) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end else begin
            sym_cnt <= sym_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_frame_controller.sv
// tb/tb_bpsk_frame_controller.sv - scoreboard bench for bpsk_frame_controller
// Three instances cover raw/gap, differential and gapless configurations.
module tb_bpsk_frame_controller;

  logic clk;
  logic rst_n0, rst_n1, rst_n2;
  logic start0, start1, start2;
  logic [7:0] data0, data1, data2;
  logic tx_bit0, tx_bit1, tx_bit2;
  logic tx_en0, tx_en1, tx_en2;
  logic strobe0, strobe1, strobe2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  bpsk_frame_controller #(.SYM_DIV(4), .GAP_SYMS(2), .DIFF_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n0), .start(start0), .data_in(data0),
    .tx_bit(tx_bit0), .tx_en(tx_en0), .sym_strobe(strobe0), .busy(busy0), .done(done0)
  );
  bpsk_frame_controller #(.SYM_DIV(4), .GAP_SYMS(2), .DIFF_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .data_in(data1),
    .tx_bit(tx_bit1), .tx_en(tx_en1), .sym_strobe(strobe1), .busy(busy1), .done(done1)
  );
  bpsk_frame_controller #(.SYM_DIV(2), .GAP_SYMS(0), .DIFF_EN(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .data_in(data2),
    .tx_bit(tx_bit2), .tx_en(tx_en2), .sym_strobe(strobe2), .busy(busy2), .done(done2)
  );

  logic [2:0] txb_v, txen_v, stb_v, busy_v, done_v;
  assign txb_v  = {tx_bit2, tx_bit1, tx_bit0};
  assign txen_v = {tx_en2, tx_en1, tx_en0};
  assign stb_v  = {strobe2, strobe1, strobe0};
  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[3][$];
  logic cur_bit[3];

  int cnt_txen, cnt_busy, cnt_strobe, cnt_done, cnt_done_fall, cnt_done_txen, spacing_err;
  int cyc, last_strobe;
  logic prev_busy, prev_txen;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int d, input logic [23:0] f);
    for (int i = 23; i >= 0; i--) exp_q[d].push_back(f[i]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts;
    cnt_txen = 0; cnt_busy = 0; cnt_strobe = 0; cnt_done = 0;
    cnt_done_fall = 0; cnt_done_txen = 0; spacing_err = 0;
    cyc = 0; last_strobe = -1; prev_busy = 1'b0; prev_txen = 1'b0;
  endtask

  task automatic sample(input int d, input int per);
    if (txen_v[d]) cnt_txen++;
    if (busy_v[d]) cnt_busy++;
    if (stb_v[d]) begin
      cnt_strobe++;
      if (last_strobe >= 0 && (cyc - last_strobe) != per) spacing_err++;
      last_strobe = cyc;
    end
    if (done_v[d]) begin
      cnt_done++;
      if (prev_busy && !busy_v[d]) cnt_done_fall++;
      if (prev_txen && !txen_v[d]) cnt_done_txen++;
    end
    prev_busy = busy_v[d];
    prev_txen = txen_v[d];
    cyc++;
  endtask

  // Scoreboard monitor: pops one expected bit per symbol strobe.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (stb_v[d]) begin
        if (exp_q[d].size() == 0) begin
          check($sformatf("unexpected_strobe_u%0d", d), 1, 0);
        end else begin
          check($sformatf("sym_bit_u%0d", d), int'(txb_v[d]), int'(exp_q[d].pop_front()));
          cur_bit[d] = txb_v[d];
        end
      end else if (txen_v[d]) begin
        check($sformatf("bit_hold_u%0d", d), int'(txb_v[d]), int'(cur_bit[d]));
      end else if (busy_v[d]) begin
        check($sformatf("gap_bit_zero_u%0d", d), int'(txb_v[d]), 0);
      end
    end
  end

  initial begin
    bit ok;
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
    for (int d = 0; d < 3; d++) cur_bit[d] = 1'b0;
    repeat (3) tick;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_tx_bit_u%0d", d), int'(txb_v[d]), 0);
      check($sformatf("rst_tx_en_u%0d", d), int'(txen_v[d]), 0);
      check($sformatf("rst_strobe_u%0d", d), int'(stb_v[d]), 0);
      check($sformatf("rst_busy_u%0d", d), int'(busy_v[d]), 0);
      check($sformatf("rst_done_u%0d", d), int'(done_v[d]), 0);
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    repeat (2) tick;

    // Basic raw frame, payload C3
    clear_counts();
    push_frame(0, 24'hAA7EC3);
    start0 = 1'b1; data0 = 8'hC3;
    tick;
    start0 = 1'b0;
    check("t1_first_strobe", int'(strobe0), 1);
    check("t1_first_bit", int'(tx_bit0), 1);
    sample(0, 4);
    for (int i = 1; i < 130; i++) begin tick; sample(0, 4); end
    check("t1_txen_cycles", cnt_txen, 96);
    check("t1_busy_cycles", cnt_busy, 104);
    check("t1_strobes", cnt_strobe, 24);
    check("t1_spacing_err", spacing_err, 0);
    check("t1_done_pulses", cnt_done, 1);
    check("t1_done_at_fall", cnt_done_fall, 1);
    check("t1_queue_left", exp_q[0].size(), 0);

    // Differential frame, payload 00: AA7E00 encodes to CC5400
    clear_counts();
    push_frame(1, 24'hCC5400);
    start1 = 1'b1; data1 = 8'h00;
    tick;
    start1 = 1'b0;
    sample(1, 4);
    for (int i = 1; i < 130; i++) begin tick; sample(1, 4); end
    check("t2_txen_cycles", cnt_txen, 96);
    check("t2_busy_cycles", cnt_busy, 104);
    check("t2_done_pulses", cnt_done, 1);
    check("t2_queue_left", exp_q[1].size(), 0);

    // Held start, then a second rise while busy
    clear_counts();
    push_frame(0, 24'hAA7E3C);
    data0 = 8'h3C;
    for (int c = 0; c < 200; c++) begin
      start0 = (c < 50) || (c >= 55);
      tick;
      sample(0, 4);
    end
    start0 = 1'b0;
    tick;
    check("t3_busy_cycles", cnt_busy, 104);
    check("t3_done_pulses", cnt_done, 1);
    check("t3_strobes", cnt_strobe, 24);
    check("t3_queue_left", exp_q[0].size(), 0);

    // Rise during done is dropped
    clear_counts();
    push_frame(0, 24'hAA7E81);
    start0 = 1'b1; data0 = 8'h81;
    tick;
    start0 = 1'b0;
    sample(0, 4);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick; sample(0, 4);
      if (done0) begin ok = 1'b1; break; end
    end
    check("t4a_done_seen", int'(ok), 1);
    check("t4a_busy_cycles", cnt_busy, 104);
    start0 = 1'b1; data0 = 8'h99;
    tick;
    start0 = 1'b0;
    repeat (3) tick;
    check("t4a_drop_busy", int'(busy0), 0);
    check("t4a_drop_txen", int'(tx_en0), 0);

    // Rise one cycle after done is accepted
    clear_counts();
    push_frame(0, 24'hAA7E18);
    start0 = 1'b1; data0 = 8'h18;
    tick;
    start0 = 1'b0;
    sample(0, 4);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick; sample(0, 4);
      if (done0) begin ok = 1'b1; break; end
    end
    check("t4b_done_seen", int'(ok), 1);
    check("t4b_busy_cycles", cnt_busy, 104);
    tick;
    push_frame(0, 24'hAA7E24);
    start0 = 1'b1; data0 = 8'h24;
    tick;
    start0 = 1'b0;
    check("t4b_txen_after_done", int'(tx_en0), 1);
    check("t4b_strobe_after_done", int'(strobe0), 1);

    // Asynchronous reset at symbol 10 of that frame
    clear_counts();
    sample(0, 4);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cnt_strobe == 11) begin ok = 1'b1; break; end
      tick; sample(0, 4);
    end
    check("t5_reached_sym10", int'(ok), 1);
    check("t5_pre_busy", int'(busy0), 1);
    check("t5_pre_txen", int'(tx_en0), 1);
    #2;
    rst_n0 = 1'b0;
    exp_q[0].delete();
    #1;
    check("t5_async_tx_bit", int'(tx_bit0), 0);
    check("t5_async_tx_en", int'(tx_en0), 0);
    check("t5_async_strobe", int'(strobe0), 0);
    check("t5_async_busy", int'(busy0), 0);
    check("t5_async_done", int'(done0), 0);
    repeat (2) tick;
    rst_n0 = 1'b1;
    tick;
    clear_counts();
    push_frame(0, 24'hAA7EF0);
    start0 = 1'b1; data0 = 8'hF0;
    tick;
    start0 = 1'b0;
    check("t5_restart_bit7", int'(tx_bit0), 1);
    sample(0, 4);
    for (int i = 1; i < 130; i++) begin tick; sample(0, 4); end
    check("t5_busy_cycles", cnt_busy, 104);
    check("t5_done_pulses", cnt_done, 1);
    check("t5_queue_left", exp_q[0].size(), 0);

    // Gapless fast config with payload changed mid-frame
    clear_counts();
    push_frame(2, 24'hAA7E5A);
    start2 = 1'b1; data2 = 8'h5A;
    tick;
    start2 = 1'b0;
    sample(2, 2);
    for (int i = 1; i < 70; i++) begin
      if (i == 10) data2 = 8'hFF;
      tick; sample(2, 2);
    end
    check("t6_busy_cycles", cnt_busy, 48);
    check("t6_txen_cycles", cnt_txen, 48);
    check("t6_strobes", cnt_strobe, 24);
    check("t6_spacing_err", spacing_err, 0);
    check("t6_done_pulses", cnt_done, 1);
    check("t6_done_at_busy_fall", cnt_done_fall, 1);
    check("t6_done_at_txen_fall", cnt_done_txen, 1);
    check("t6_queue_left", exp_q[2].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
